// File: rtl/mul_pkg.sv
// Shared parameters and types for the 8x8 multiplier datapath.
package mul_pkg;
  localparam int W     = 8;
  localparam int PW    = 2 * W;
  localparam int IDX_W = $clog2(W);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;
endpackage

// File: rtl/pp_row_shifter.sv
// Zero-extends a W-bit partial-product row to 2W bits and weights it by its index.
module pp_row_shifter #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     row_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [2*W-1:0]   shifted_o
);

  assign shifted_o = {{W{1'b0}}, row_i} << idx_i;

endmodule

// File: rtl/pp_row_accumulator.sv
// Accumulates shifted partial-product rows into a 2W-bit product and flags
// any product whose row-index set is not exactly {0..W-1}, each once.
module pp_row_accumulator #(
  parameter int W     = mul_pkg::W,
  parameter int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [W-1:0]     row_data,
  input  logic [IDX_W-1:0] row_idx,
  input  logic             row_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   product,
  output logic             out_err
);
  import mul_pkg::*;

  state_e           state_q;
  logic [2*W-1:0]   acc_q;
  logic [2*W-1:0]   acc_d;
  logic [W-1:0]     seen_q;
  logic [W-1:0]     seen_d;
  logic             dup_q;
  logic             dup_d;
  logic [2*W-1:0]   product_q;
  logic             err_q;
  logic [2*W-1:0]   row_shifted;
  logic [W-1:0]     idx_onehot;

  pp_row_shifter #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_shifter (
    .row_i     (row_data),
    .idx_i     (row_idx),
    .shifted_o (row_shifted)
  );

  // One-hot decode avoids indexing seen_q out of range when W is not a power of two.
  for (genvar gi = 0; gi < W; gi++) begin : g_onehot
    assign idx_onehot[gi] = (row_idx == IDX_W'(gi));
  end

  always_comb begin
    acc_d  = acc_q + row_shifted;
    seen_d = seen_q | idx_onehot;
    dup_d  = dup_q | (|(seen_q & idx_onehot));
  end

  assign row_ready = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign product   = product_q;
  assign out_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      seen_q    <= '0;
      dup_q     <= 1'b0;
      product_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (row_valid) begin
            acc_q  <= acc_d;
            seen_q <= seen_d;
            dup_q  <= dup_d;
            if (row_last) begin
              product_q <= acc_d;
              err_q     <= dup_d | ~(&seen_d);
              state_q   <= HOLD;
            end
          end
        end
        HOLD: begin
          // Rows are refused here; partial state is cleared only on hand-off.
          if (out_ready) begin
            acc_q   <= '0;
            seen_q  <= '0;
            dup_q   <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_row_accumulator.sv
// Directed bench for pp_row_accumulator with an expected-product scoreboard.
module tb_pp_row_accumulator;

  logic        clk;
  logic        rst_n;
  logic        row_valid;
  logic        row_ready;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        row_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        out_err;

  typedef struct {
    logic [15:0] p;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   accept_cyc = 0;

  pp_row_accumulator #(.W(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each delivered product against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: observed product=%0h expected none", product);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", 32'(product), 32'(e.p));
        check("out_err", 32'(out_err), 32'(e.e));
        $display("out: product=%04h err=%0b", product, out_err);
      end
    end
  end

  // Presents one row and returns just after the edge that accepts it.
  task automatic send_row(input logic [7:0] d, input int idx, input logic last);
    int waited;
    waited    = 0;
    row_valid = 1'b1;
    row_data  = d;
    row_idx   = idx[2:0];
    row_last  = last;
    @(negedge clk);
    while (!row_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!row_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL row_accept_timeout: observed row_ready=0 expected 1 within 50 cycles");
      row_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    $display("row: data=%02h idx=%0d last=%0b cyc=%0d", d, idx, last, accept_cyc);
  endtask

  task automatic send_seq(input logic [7:0] d[8], input int ix[8], output int first_c, output int last_c);
    first_c = 0;
    for (int i = 0; i < 8; i++) begin
      send_row(d[i], ix[i], (i == 7));
      if (i == 0) first_c = accept_cyc;
    end
    last_c = accept_cyc;
  endtask

  task automatic expect_valid_next(input string tag);
    row_valid = 1'b0;
    @(negedge clk);
    check(tag, 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ff_d[8];
  int         in_ix[8];
  logic [7:0] sh_d[8];
  int         sh_ix[8];
  int         c_first, c_last, c_first2, c_last2, m_cyc;

  initial begin
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      ff_d[i]  = 8'hFF;
      in_ix[i] = i;
    end
    sh_d  = '{8'h0D, 8'h0D, 8'h00, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00};
    sh_ix = '{3, 0, 7, 1, 2, 4, 5, 6};

    rst_n     = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    row_idx   = '0;
    row_last  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_row_ready", 32'(row_ready), 32'd1);
    check("rst_product",   32'(product),   32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    @(posedge clk);
    #1;

    // Full 0xFF x 0xFF, rows in order
    e.p = 16'hFE01; e.e = 1'b0; sb.push_back(e);
    send_seq(ff_d, in_ix, c_first, c_last);
    check("throughput", 32'(c_last - c_first), 32'd7);
    expect_valid_next("latency_full");

    // 0x0D x 0x0B, shuffled indices
    e.p = 16'h008F; e.e = 1'b0; sb.push_back(e);
    send_seq(sh_d, sh_ix, c_first, c_last);
    expect_valid_next("latency_shuffled");

    // Backpressure with a pending single-row product behind it
    out_ready = 1'b0;
    e.p = 16'hFE01; e.e = 1'b0; sb.push_back(e);
    send_seq(ff_d, in_ix, c_first, c_last);
    e.p = 16'h0005; e.e = 1'b1; sb.push_back(e);
    row_valid = 1'b1;
    row_data  = 8'h05;
    row_idx   = 3'd0;
    row_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_row_ready", 32'(row_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_product",   32'(product),   32'hFE01);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    m_cyc = cyc;
    send_row(8'h05, 0, 1'b1);
    check("bp_resume_cycle", 32'(accept_cyc), 32'(m_cyc + 1));
    expect_valid_next("latency_single");

    // Duplicate idx 0, all others present
    e.p = 16'h0002; e.e = 1'b1; sb.push_back(e);
    send_row(8'h01, 0, 1'b0);
    send_row(8'h01, 0, 1'b0);
    for (int i = 1; i < 8; i++) send_row(8'h00, i, (i == 7));
    expect_valid_next("latency_dup");

    // Asynchronous reset in the middle of a product
    for (int i = 0; i < 4; i++) send_row(8'hFF, i, 1'b0);
    row_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_row_ready", 32'(row_ready), 32'd1);
    check("mid_rst_product",   32'(product),   32'd0);
    check("mid_rst_out_err",   32'(out_err),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e.p = 16'hFE01; e.e = 1'b0; sb.push_back(e);
    send_seq(ff_d, in_ix, c_first, c_last);
    expect_valid_next("latency_after_rst");

    // Back-to-back products with out_ready held high
    e.p = 16'hFE01; e.e = 1'b0; sb.push_back(e);
    e.p = 16'h008F; e.e = 1'b0; sb.push_back(e);
    send_seq(ff_d, in_ix, c_first, c_last);
    send_seq(sh_d, sh_ix, c_first2, c_last2);
    check("b2b_bubble", 32'(c_first2 - c_last), 32'd2);
    expect_valid_next("latency_b2b");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
